// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC issue sequencer: instruction classes,
// ALU control codes, branch conditions, FSM states and instruction fields.
package kgp_risc_pkg;

  // Instruction class codes (instr[31:30])
  localparam logic [1:0] CLS_RR   = 2'b00;
  localparam logic [1:0] CLS_RI   = 2'b01;
  localparam logic [1:0] CLS_ADDR = 2'b10;
  localparam logic [1:0] CLS_BR   = 2'b11;

  // ALU control codes
  localparam logic [5:0] ALU_ADDR    = 6'h00;
  localparam logic [5:0] ALU_RR_BASE = 6'h10;
  localparam logic [5:0] ALU_MULTU   = 6'h13;
  localparam logic [5:0] ALU_MULT    = 6'h14;
  localparam logic [5:0] ALU_RR_LAST = 6'h18;
  localparam logic [5:0] ALU_RI_BASE = 6'h20;
  localparam logic [5:0] ALU_RI_LAST = 6'h24;
  localparam logic [5:0] ALU_PASS_A  = 6'h30;
  localparam logic [5:0] ALU_PASS_B  = 6'h31;
  localparam logic [5:0] ALU_ILLEGAL = 6'h3F;

  // Highest legal func value per class
  localparam logic [3:0] RR_FUNC_MAX = 4'd8;
  localparam logic [3:0] RI_FUNC_MAX = 4'd4;
  localparam logic [3:0] BR_FUNC_MAX = 4'd7;

  // Instruction field bit positions
  localparam int CLASS_MSB = 31;
  localparam int CLASS_LSB = 30;
  localparam int FUNC_MSB  = 29;
  localparam int FUNC_LSB  = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'd0,
    BR_Z      = 3'd1,
    BR_NZ     = 3'd2,
    BR_C      = 3'd3,
    BR_NC     = 3'd4,
    BR_S      = 3'd5,
    BR_NS     = 3'd6,
    BR_O      = 3'd7
  } br_cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_BR   = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

  // Branch outcome from a {c,z,s,o} flag vector
  function automatic logic branch_taken(input br_cond_e cond, input logic [3:0] flags);
    logic taken;
    case (cond)
      BR_ALWAYS: taken = 1'b1;
      BR_Z:      taken = flags[2];
      BR_NZ:     taken = ~flags[2];
      BR_C:      taken = flags[3];
      BR_NC:     taken = ~flags[3];
      BR_S:      taken = flags[1];
      BR_NS:     taken = ~flags[1];
      BR_O:      taken = flags[0];
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder: maps class/func to the 6-bit ALU control
// code and classifies the instruction (branch, multiply, flag-setting, illegal).
// Illegal encodings always decode to ALU_ILLEGAL; the sequencer decides whether
// they trap (ALU_SEQ_ILLEGAL_TRAP_EN) or write back normally.
module alu_decode
  import kgp_risc_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  alu_ctrl,
  output logic        is_branch,
  output logic        is_mult,
  output logic        sets_flags,
  output logic        illegal
);

  logic [1:0] w_class;
  logic [3:0] w_func;

  assign w_class = instr[CLASS_MSB:CLASS_LSB];
  assign w_func  = instr[FUNC_MSB:FUNC_LSB];

  // Class/func to control code and instruction attributes
  always_comb begin
    alu_ctrl   = ALU_ILLEGAL;
    is_branch  = 1'b0;
    sets_flags = 1'b0;
    illegal    = 1'b1;
    case (w_class)
      CLS_RR: begin
        if (w_func <= RR_FUNC_MAX) begin
          alu_ctrl   = {2'b01, w_func};
          sets_flags = 1'b1;
          illegal    = 1'b0;
        end else begin
          illegal    = 1'b1;
        end
      end
      CLS_RI: begin
        if (w_func <= RI_FUNC_MAX) begin
          alu_ctrl   = {2'b10, w_func};
          sets_flags = 1'b1;
          illegal    = 1'b0;
        end else begin
          illegal    = 1'b1;
        end
      end
      CLS_ADDR: begin
        alu_ctrl = ALU_ADDR;
        illegal  = 1'b0;
      end
      CLS_BR: begin
        if (w_func <= BR_FUNC_MAX) begin
          alu_ctrl  = ALU_PASS_A;
          is_branch = 1'b1;
          illegal   = 1'b0;
        end else begin
          illegal   = 1'b1;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign is_mult = (alu_ctrl == ALU_MULTU) || (alu_ctrl == ALU_MULT);

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side sequencer for the KGP-RISC ALU: accepts one instruction, holds
// decoded operands stable while the ALU evaluates (multi-cycle for multiply),
// captures result/flags, then writes back or resolves a branch.
// Optional build macro: ALU_SEQ_ILLEGAL_TRAP_EN (illegal encodings trap
// instead of writing back zero).
module alu_sequencer
  import kgp_risc_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [5:0]  alu_ctrl,
  output logic [15:0] alu_imm,
  input  logic [31:0] alu_res,
  input  logic [31:0] alu_res_mult,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_s,
  input  logic        alu_o,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_data_hi,
  output logic        br_valid,
  output logic        br_taken,
  output logic [3:0]  flags,
  output logic        illegal
);

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);

  logic [5:0]  w_ctrl;
  logic        w_is_branch;
  logic        w_is_mult;
  logic        w_sets_flags;
  logic        w_illegal;

  seq_state_e  r_state;
  logic        r_in_ready;
  logic [3:0]  r_cnt;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [5:0]  r_ctrl;
  logic [15:0] r_imm;
  br_cond_e    r_cond;
  logic        r_is_branch;
  logic        r_is_mult;
  logic        r_sets_flags;
  logic        r_dec_illegal;
  logic        r_wb_valid;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic [31:0] r_wb_data_hi;
  logic        r_br_valid;
  logic        r_br_taken;
  logic [3:0]  r_flags;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic        r_illegal;
`endif

  alu_decode u_decode (
    .instr      (instr),
    .alu_ctrl   (w_ctrl),
    .is_branch  (w_is_branch),
    .is_mult    (w_is_mult),
    .sets_flags (w_sets_flags),
    .illegal    (w_illegal)
  );

  // Sequencer FSM with exec counter, operand hold and result/flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b1;
      r_cnt         <= 4'd0;
      r_rs          <= 5'd0;
      r_rt          <= 5'd0;
      r_ctrl        <= ALU_ADDR;
      r_imm         <= 16'd0;
      r_cond        <= BR_ALWAYS;
      r_is_branch   <= 1'b0;
      r_is_mult     <= 1'b0;
      r_sets_flags  <= 1'b0;
      r_dec_illegal <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_addr     <= 5'd0;
      r_wb_data     <= 32'd0;
      r_wb_data_hi  <= 32'd0;
      r_br_valid    <= 1'b0;
      r_br_taken    <= 1'b0;
      r_flags       <= 4'b0000;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      r_illegal     <= 1'b0;
`endif
    end else begin
      r_br_valid <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      r_illegal  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_rs          <= instr[RS_MSB:RS_LSB];
            r_rt          <= instr[RT_MSB:RT_LSB];
            r_imm         <= instr[IMM_MSB:IMM_LSB];
            r_ctrl        <= w_ctrl;
            r_cond        <= br_cond_e'(instr[FUNC_LSB+2:FUNC_LSB]);
            r_is_branch   <= w_is_branch;
            r_is_mult     <= w_is_mult;
            r_sets_flags  <= w_sets_flags;
            r_dec_illegal <= w_illegal;
            r_cnt         <= w_is_mult ? MULT_LAST : 4'd0;
            r_in_ready    <= 1'b0;
            r_state       <= ST_EXEC;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            r_illegal     <= w_illegal;
`endif
          end
        end
        ST_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          if (r_dec_illegal) begin
            // Trapped encodings end here: no writeback, flags or branch
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else
`endif
          if (r_is_branch) begin
            // Branch is resolved on the registered flags, never live ALU flags
            r_br_valid <= 1'b1;
            r_br_taken <= branch_taken(r_cond, r_flags);
            r_state    <= ST_BR;
          end else begin
            r_wb_valid   <= 1'b1;
            r_wb_addr    <= r_rt;
            r_wb_data    <= r_dec_illegal ? 32'd0 : alu_res;
            r_wb_data_hi <= r_is_mult ? alu_res_mult : 32'd0;
            if (r_sets_flags) begin
              r_flags <= {alu_c, alu_z, alu_s, alu_o};
            end
            r_state <= ST_WB;
          end
        end
        ST_BR: begin
          r_br_taken <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_WB: begin
          if (wb_ready) begin
            r_wb_valid <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_wb_valid <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign rs_addr    = r_rs;
  assign rt_addr    = r_rt;
  assign alu_ctrl   = r_ctrl;
  assign alu_imm    = r_imm;
  assign wb_valid   = r_wb_valid;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign wb_data_hi = r_wb_data_hi;
  assign br_valid   = r_br_valid;
  assign br_taken   = r_br_taken;
  assign flags      = r_flags;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign illegal    = r_illegal;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer (default build, trap macro undefined).
// The bench plays the ALU: results are a hash of the presented control/operands
// and the current cycle, so capture timing and operand stability are visible.
module tb_alu_sequencer;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [4:0]  rs_addr, rt_addr, wb_addr;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_imm;
  logic [31:0] alu_res, alu_res_mult, wb_data, wb_data_hi;
  logic        alu_c, alu_z, alu_s, alu_o;
  logic        wb_valid, br_valid, br_taken, illegal;
  logic        wb_ready = 1'b0;
  logic [3:0]  flags;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int free_cyc = 0;
  bit mon_en = 1'b0;
  logic [3:0] model_flags = 4'b0000;

  typedef struct {
    bit          is_br;
    bit          taken;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [5:0]  ctrl;
    logic [31:0] data;
    logic [31:0] hi;
    logic [3:0]  flags;
    int          due;
    int          hold;
    int          waited;
    bit          seen;
  } exp_t;

  exp_t q[$];
  exp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ALU stand-in ----------------
  function automatic logic [31:0] alu_fn_res(logic [5:0] c, logic [4:0] a, logic [4:0] b,
                                             logic [15:0] im, int t);
    if (c == 6'h3F) return 32'h0;
    if (im[2:0] == 3'b000) return 32'h0;
    return ({26'h0, c} * 32'h9E3779B1) ^ ({27'h0, a} << 7) ^ ({27'h0, b} << 13)
           ^ {16'h0, im} ^ (32'(t) * 32'h85EBCA6B);
  endfunction

  function automatic logic [31:0] alu_fn_hi(logic [5:0] c, logic [4:0] a, logic [4:0] b,
                                            logic [15:0] im, int t);
    if (c == 6'h3F) return 32'h0;
    return alu_fn_res(c, a, b, im, t) ^ 32'hA5A50F0F ^ (32'(t) << 3);
  endfunction

  function automatic logic [3:0] alu_fn_flags(logic [5:0] c, logic [4:0] a, logic [4:0] b,
                                              logic [15:0] im, int t);
    logic [31:0] r;
    logic [31:0] k;
    r = alu_fn_res(c, a, b, im, t);
    k = (32'(t) * 32'h2545F491) ^ {26'h0, c} ^ {16'h0, im};
    return {k[7], (r == 32'h0), r[31], k[13]};
  endfunction

  assign alu_res      = alu_fn_res(alu_ctrl, rs_addr, rt_addr, alu_imm, cyc);
  assign alu_res_mult = alu_fn_hi(alu_ctrl, rs_addr, rt_addr, alu_imm, cyc);
  assign {alu_c, alu_z, alu_s, alu_o} = alu_fn_flags(alu_ctrl, rs_addr, rt_addr, alu_imm, cyc);

  alu_sequencer #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .alu_ctrl(alu_ctrl), .alu_imm(alu_imm),
    .alu_res(alu_res), .alu_res_mult(alu_res_mult),
    .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s), .alu_o(alu_o),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_data_hi(wb_data_hi), .br_valid(br_valid), .br_taken(br_taken),
    .flags(flags), .illegal(illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit cond_met(logic [3:0] f, logic [3:0] fl);
    case (f)
      4'd0: return 1'b1;
      4'd1: return fl[2];
      4'd2: return !fl[2];
      4'd3: return fl[3];
      4'd4: return !fl[3];
      4'd5: return fl[1];
      4'd6: return !fl[1];
      default: return fl[0];
    endcase
  endfunction

  task automatic push_op(input logic [31:0] ins, input int hold, input int a);
    exp_t e;
    logic [1:0] cl;
    logic [3:0] f;
    bit legal;
    bit mult;
    int n;
    cl = ins[31:30];
    f  = ins[29:26];
    case (cl)
      2'd0: legal = (f <= 4'd8);
      2'd1: legal = (f <= 4'd4);
      2'd2: legal = 1'b1;
      default: legal = (f <= 4'd7);
    endcase
    if (!legal)          e.ctrl = 6'h3F;
    else if (cl == 2'd0) e.ctrl = {2'b01, f};
    else if (cl == 2'd1) e.ctrl = {2'b10, f};
    else if (cl == 2'd2) e.ctrl = 6'h00;
    else                 e.ctrl = 6'h30;
    mult = (e.ctrl == 6'h13) || (e.ctrl == 6'h14);
    n = mult ? MC : 1;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.imm = ins[15:0];
    e.due = a + n + 1;
    e.hold = hold;
    e.waited = 0;
    e.seen = 1'b0;
    e.is_br = legal && (cl == 2'd3);
    e.taken = e.is_br ? cond_met(f, model_flags) : 1'b0;
    e.data = legal ? alu_fn_res(e.ctrl, e.rs, e.rt, e.imm, a + n) : 32'h0;
    e.hi = mult ? alu_fn_hi(e.ctrl, e.rs, e.rt, e.imm, a + n) : 32'h0;
    if (legal && (cl <= 2'd1))
      model_flags = alu_fn_flags(e.ctrl, e.rs, e.rt, e.imm, a + n);
    e.flags = model_flags;
    q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  task automatic issue(input logic [31:0] ins, input int hold, input bit junk);
    int budget;
    bit done;
    budget = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk); #2;
      chk("in_ready", in_ready, (cyc >= free_cyc));
      if (in_ready) begin
        instr = ins;
        in_valid = 1'b1;
        push_op(ins, hold, cyc);
        free_cyc = 32'h7fffffff;
        done = 1'b1;
      end else begin
        in_valid = junk;
        instr = $urandom;
        budget++;
        if (budget > 200) begin
          errors++; checks++;
          $display("FAIL issue_timeout: in_ready stuck low, expected high by cycle %0d", free_cyc);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #2;
      chk("in_ready_idle", in_ready, (cyc >= free_cyc));
      in_valid = 1'b0;
      instr = $urandom;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      wb_ready = 1'b0;
      chk("illegal_low", illegal, 1'b0);
      if (q.size() > 0 && !q[0].seen && cyc > q[0].due) begin
        errors++; checks++;
        $display("FAIL out_timeout: no output at cycle %0d, expected at %0d", cyc, q[0].due);
        void'(q.pop_front());
        free_cyc = cyc + 1;
      end
      if (wb_valid || br_valid) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_out: wb_valid=%0b br_valid=%0b with nothing pending", wb_valid, br_valid);
        end else begin
          me = q[0];
          if (!me.seen) chk("latency", 64'(cyc), 64'(me.due));
          me.seen = 1'b1;
          chk("alu_ctrl_hold", alu_ctrl, me.ctrl);
          chk("rs_hold", rs_addr, me.rs);
          chk("rt_hold", rt_addr, me.rt);
          chk("imm_hold", alu_imm, me.imm);
          chk("flags", flags, me.flags);
          if (me.is_br) begin
            chk("br_valid", br_valid, 1'b1);
            chk("wb_valid_on_br", wb_valid, 1'b0);
            chk("br_taken", br_taken, me.taken);
            void'(q.pop_front());
            free_cyc = cyc + 1;
          end else begin
            chk("wb_valid", wb_valid, 1'b1);
            chk("br_valid_on_wb", br_valid, 1'b0);
            chk("wb_addr", wb_addr, me.rt);
            chk("wb_data", wb_data, me.data);
            chk("wb_data_hi", wb_data_hi, me.hi);
            if (me.waited >= me.hold) begin
              wb_ready = 1'b1;
              void'(q.pop_front());
              free_cyc = cyc + 1;
            end else begin
              me.waited++;
              q[0] = me;
            end
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    logic [31:0] ins;
    logic [1:0] dcls [11];
    logic [3:0] dfn [11];
    dcls = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    dfn  = '{4'd2, 4'd3, 4'd4, 4'd2, 4'd1, 4'd2, 4'd9, 4'd7, 4'd0, 4'd9, 4'd15};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_br_valid", br_valid, 1'b0);
    chk("rst_br_taken", br_taken, 1'b0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_alu_ctrl", alu_ctrl, 6'h00);
    chk("rst_wb_data", {wb_data, wb_data_hi}, 64'h0);
    chk("rst_addrs", {rs_addr, rt_addr, wb_addr, alu_imm}, 64'h0);
    chk("rst_illegal", illegal, 1'b0);
    rst = 1'b0;

    // Reset while a writeback is stalled
    @(negedge clk); #2;
    instr = {2'b00, 4'd2, 5'd7, 5'd9, 16'h1234};
    in_valid = 1'b1;
    @(negedge clk); #2;
    in_valid = 1'b0;
    budget = 0;
    while (!wb_valid && budget < 10) begin
      @(negedge clk); #2;
      budget++;
    end
    chk("midwb_wb_valid", wb_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    chk("midwb_rst_wb_valid", wb_valid, 1'b0);
    chk("midwb_rst_in_ready", in_ready, 1'b1);
    chk("midwb_rst_flags", flags, 4'b0000);
    chk("midwb_rst_ctrl", alu_ctrl, 6'h00);

    model_flags = 4'b0000;
    free_cyc = 0;
    mon_en = 1'b1;

    // Directed: add (stalled wb), multu, mult, add z=1, branches, illegal, addr
    for (int i = 0; i < 11; i++) begin
      ins = {dcls[i], dfn[i], 5'(i + 1), 5'(i + 3), 16'(i * 16)};
      issue(ins, (i == 0) ? 3 : 0, 1'b0);
      idle(1);
    end

    // Randomized: mixed classes, random wb stalls, in_valid sometimes held while busy
    for (int i = 0; i < 150; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[29] = 1'b0;
      issue(ins, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    budget = 0;
    while (q.size() != 0 && budget < 300) begin
      @(negedge clk); #2;
      in_valid = 1'b0;
      budget++;
    end
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain: %0d outputs still pending, expected 0", q.size());
    end
    idle(3);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
